// File: rtl/add_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller and its slice.
package add_ctrl_pkg;

    // Width of the shared carry-lookahead adder slice.
    localparam int unsigned SLICE_W = 4;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Slice index width; a single-slice build still needs a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned n_slices);
        return (n_slices > 1) ? $clog2(n_slices) : 1;
    endfunction

endpackage

// File: rtl/cla_adder.sv
// 4-bit carry-lookahead adder slice: out/cout = in1 + in2 + cin.
module cla_adder
    import add_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] in1,
    input  logic [SLICE_W-1:0] in2,
    input  logic               cin,
    output logic [SLICE_W-1:0] out,
    output logic               cout
);

    logic [SLICE_W-1:0] gen;
    logic [SLICE_W-1:0] prop;
    logic [SLICE_W:0]   carry;

    assign gen  = in1 & in2;
    assign prop = in1 ^ in2;

    // Flattened lookahead carries, every carry computed directly from cin.
    always_comb begin
        carry    = '0;
        carry[0] = cin;
        carry[1] = gen[0]
                 | (prop[0] & cin);
        carry[2] = gen[1]
                 | (prop[1] & gen[0])
                 | (prop[1] & prop[0] & cin);
        carry[3] = gen[2]
                 | (prop[2] & gen[1])
                 | (prop[2] & prop[1] & gen[0])
                 | (prop[2] & prop[1] & prop[0] & cin);
        carry[4] = gen[3]
                 | (prop[3] & gen[2])
                 | (prop[3] & prop[2] & gen[1])
                 | (prop[3] & prop[2] & prop[1] & gen[0])
                 | (prop[3] & prop[2] & prop[1] & prop[0] & cin);
    end

    assign out  = prop ^ carry[SLICE_W-1:0];
    assign cout = carry[SLICE_W];

endmodule

// File: rtl/add16_seq_ctrl.sv
// Nibble-serial adder: one shared 4-bit slice processes a word over
// N_SLICES cycles, with a valid/ready handshake on both sides.
module add16_seq_ctrl
    import add_ctrl_pkg::*;
#(
    parameter int unsigned N_SLICES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SLICE_W*N_SLICES-1:0] a,
    input  logic [SLICE_W*N_SLICES-1:0] b,
    input  logic                        cin,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SLICE_W*N_SLICES-1:0] sum,
    output logic                        cout,
    output logic                        ovf
);

    localparam int unsigned         IDX_W    = idx_width(N_SLICES);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_SLICES - 1);

    state_e                             state_q;
    logic [N_SLICES-1:0][SLICE_W-1:0]   a_q;
    logic [N_SLICES-1:0][SLICE_W-1:0]   b_q;
    logic [N_SLICES-1:0][SLICE_W-1:0]   sum_q;
    logic [IDX_W-1:0]                   idx_q;
    logic                               carry_q;
    logic                               cout_q;
    logic                               ovf_q;
    logic                               in_ready_q;
    logic                               out_valid_q;

    logic [SLICE_W-1:0]                 slice_a_d;
    logic [SLICE_W-1:0]                 slice_b_d;
    logic [SLICE_W-1:0]                 slice_sum_d;
    logic                               slice_cout_d;
    logic                               ovf_d;

    // Current nibble of the captured operands feeds the shared slice.
    assign slice_a_d = a_q[idx_q];
    assign slice_b_d = b_q[idx_q];

    cla_adder u_slice (
        .in1  (slice_a_d),
        .in2  (slice_b_d),
        .cin  (carry_q),
        .out  (slice_sum_d),
        .cout (slice_cout_d)
    );

    // Signed overflow, only meaningful while the top nibble is in the slice.
    assign ovf_d = (a_q[N_SLICES-1][SLICE_W-1] == b_q[N_SLICES-1][SLICE_W-1])
                && (slice_sum_d[SLICE_W-1] != a_q[N_SLICES-1][SLICE_W-1]);

    // Controller, datapath registers and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= cin;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_q[idx_q] <= slice_sum_d;
                    carry_q      <= slice_cout_d;
                    if (idx_q == IDX_LAST) begin
                        cout_q      <= slice_cout_d;
                        ovf_q       <= ovf_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_add16_seq_ctrl.sv
// Scoreboard bench for add16_seq_ctrl: driver pushes expected results,
// a negedge monitor pops and compares whenever out_valid is presented.
module tb_add16_seq_ctrl;

    localparam int unsigned N = 4;
    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        int           acc;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cycle    = 0;
    logic ov_prev  = 1'b0;
    bit   rand_ready = 1'b0;
    logic ready_force = 1'b1;

    add16_seq_ctrl #(.N_SLICES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Consumer: random stalls or a forced level, changed just after the edge.
    always @(posedge clk) begin
        #2;
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cycle);
    endfunction

    function automatic void fail(input string name);
        n_checks++;
        $display("FAIL %s (cycle %0d)", name, cycle);
    endfunction

    // Reference: plain integer arithmetic on the mathematical values.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input int acc);
        exp_t        e;
        int unsigned total;
        int          sx;
        int          sy;
        int          sr;
        total = 32'(x) + 32'(y) + 32'(c);
        sx    = $signed(x);
        sy    = $signed(y);
        sr    = sx + sy + (c ? 1 : 0);
        e.s   = total[W-1:0];
        e.c   = total[W];
        e.v   = (sr > 32767) || (sr < -32768);
        e.acc = acc;
        return e;
    endfunction

    // Monitor: compare every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sbq.size() == 0) begin
                fail("unexpected_result");
            end else begin
                if (!ov_prev) chk("latency", 32'(cycle - sbq[0].acc), N);
                chk("sum",  32'(sum),  32'(sbq[0].s));
                chk("cout", 32'(cout), 32'(sbq[0].c));
                chk("ovf",  32'(ovf),  32'(sbq[0].v));
                if (out_ready) void'(sbq.pop_front());
            end
        end
        ov_prev = out_valid && !rst;
    end

    // Offer one operand set; caller is at a negedge, returns at a negedge.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        int g = 0;
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            fail("send_timeout");
            return;
        end
        in_valid = 1'b1;
        a = ta;
        b = tb;
        cin = tc;
        sbq.push_back(model(ta, tb, tc, cycle + 1));
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
    endtask

    task automatic wait_valid();
        int g = 0;
        while (!out_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!out_valid) fail("out_valid_timeout");
    endtask

    task automatic drain();
        int g = 0;
        while ((sbq.size() != 0 || out_valid) && g < 400) begin
            @(negedge clk);
            g++;
        end
        if (sbq.size() != 0 || out_valid) fail("drain_timeout");
    endtask

    task automatic run_known(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                             input logic [W-1:0] es, input logic ec, input logic ev);
        send(ta, tb, tc);
        wait_valid();
        chk("known_sum",  32'(sum),  32'(es));
        chk("known_cout", 32'(cout), 32'(ec));
        chk("known_ovf",  32'(ovf),  32'(ev));
        drain();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum",       32'(sum),       32'd0);
        chk("rst_cout",      32'(cout),      32'd0);
        chk("rst_ovf",       32'(ovf),       32'd0);
        rst = 1'b0;

        // Directed arithmetic corners, accepted on the first edge after reset.
        run_known(16'h0002, 16'hFFFE, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_known(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_known(16'h0006, 16'h0006, 1'b1, 16'h000D, 1'b0, 1'b0);
        run_known(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_known(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);

        // Back-pressure: result must hold while new offers are refused.
        ready_force = 1'b0;
        send(16'h1234, 16'h4321, 1'b0);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            chk("hold_sum",      32'(sum),       32'h5555);
            chk("hold_cout",     32'(cout),      32'd0);
            chk("hold_ovf",      32'(ovf),       32'd0);
            chk("hold_in_ready", 32'(in_ready),  32'd0);
            chk("hold_valid",    32'(out_valid), 32'd1);
            in_valid = 1'b1;
            a = 16'h1111;
            b = 16'h1111;
            @(negedge clk);
        end
        in_valid = 1'b0;
        ready_force = 1'b1;
        drain();
        repeat (8) @(negedge clk);
        chk("no_extra_result", 32'(out_valid), 32'd0);

        // Reset two cycles into a run aborts it cleanly.
        send(16'h0F0F, 16'h00F1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sum",       32'(sum),       32'd0);
        chk("mid_rst_cout",      32'(cout),      32'd0);
        chk("mid_rst_ovf",       32'(ovf),       32'd0);
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        run_known(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        // Random regression with consumer stalls.
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            send(W'($urandom), W'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        drain();
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
